// File: rtl/id_ex_stage_pkg.sv
// Shared widths, control-word layout and payload types for the ID/EX pipeline register.
package id_ex_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CTRL_W = 12;
    localparam int unsigned REG_W  = 5;

    // Decoder control word, MSB first
    typedef struct packed {
        logic       branch;
        logic       memread;
        logic [1:0] memtoreg;
        logic [2:0] aluop;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] branch_signal;
    } ctrl_t;

    // All-zero word: no write, no memory access, no branch
    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [XLEN-1:0]  imm;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [2:0]       funct3;
        logic             funct7b5;
        ctrl_t            ctrl;
    } ex_payload_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs, EX-side outputs and stall/flush handshake of the ID/EX stage.
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [REG_W-1:0]  id_rs1;
    logic [REG_W-1:0]  id_rs2;
    logic [REG_W-1:0]  id_rd;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic [2:0]        id_funct3;
    logic              id_funct7b5;
    logic [CTRL_W-1:0] id_ctrl;
    logic              ex_flush;
    logic              ex_hold;

    logic              id_stall;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_rs1_data;
    logic [XLEN-1:0]   ex_rs2_data;
    logic [XLEN-1:0]   ex_imm;
    logic [REG_W-1:0]  ex_rs1;
    logic [REG_W-1:0]  ex_rs2;
    logic [REG_W-1:0]  ex_rd;
    logic [2:0]        ex_funct3;
    logic              ex_funct7b5;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_uses_rs1, id_uses_rs2, id_funct3, id_funct7b5, id_ctrl, ex_flush, ex_hold,
        input  id_stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
               ex_rd, ex_funct3, ex_funct7b5, ex_ctrl, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_uses_rs1, id_uses_rs2, id_funct3, id_funct7b5, id_ctrl, ex_flush, ex_hold,
        output id_stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
               ex_rd, ex_funct3, ex_funct7b5, ex_ctrl, bubble_cnt
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use detector: a load in EX whose rd is read by the valid instruction in ID.
module id_ex_stage_hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic             ex_valid,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  logic             id_uses_rs1,
    input  logic [REG_W-1:0] id_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] id_rs2,
    output logic             lu_c
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

    // x0 is never really written, so it cannot be a source of stale data
    assign lu_c = ex_valid && ex_memread && (ex_rd != REG_W'(0)) && id_valid && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and downstream hold.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);

    ex_payload_t      ex_q, ex_d;
    logic             valid_q, valid_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu_c;
    ex_payload_t      id_payload;

    id_ex_stage_hazard_detect u_hazard (
        .ex_valid    (valid_q),
        .ex_memread  (ex_q.ctrl.memread),
        .ex_rd       (ex_q.rd),
        .id_valid    (bus.id_valid),
        .id_uses_rs1 (bus.id_uses_rs1),
        .id_rs1      (bus.id_rs1),
        .id_uses_rs2 (bus.id_uses_rs2),
        .id_rs2      (bus.id_rs2),
        .lu_c        (lu_c)
    );

    // A pending or current flush already kills the consumer, so it needs no stall
    assign bus.id_stall = bus.ex_hold | (lu_c & ~bus.ex_flush & ~pend_q);

    always_comb begin
        id_payload          = '0;
        id_payload.pc       = bus.id_pc;
        id_payload.rs1_data = bus.id_rs1_data;
        id_payload.rs2_data = bus.id_rs2_data;
        id_payload.imm      = bus.id_imm;
        id_payload.rs1      = bus.id_rs1;
        id_payload.rs2      = bus.id_rs2;
        id_payload.rd       = bus.id_rd;
        id_payload.funct3   = bus.id_funct3;
        id_payload.funct7b5 = bus.id_funct7b5;
        id_payload.ctrl     = bus.id_valid ? ctrl_t'(bus.id_ctrl) : CTRL_BUBBLE;
    end

    // Next-state: hold > flush/pending flush > load-use bubble > capture
    always_comb begin
        ex_d    = ex_q;
        valid_d = valid_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        if (bus.ex_hold) begin
            pend_d = pend_q | bus.ex_flush;
        end else if (bus.ex_flush || pend_q || lu_c) begin
            ex_d      = '0;
            ex_d.ctrl = CTRL_BUBBLE;
            valid_d   = 1'b0;
            pend_d    = 1'b0;
            cnt_d     = sat_inc(cnt_q);
        end else begin
            ex_d    = id_payload;
            valid_d = bus.id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q    <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ex_valid    = valid_q;
    assign bus.ex_pc       = ex_q.pc;
    assign bus.ex_rs1_data = ex_q.rs1_data;
    assign bus.ex_rs2_data = ex_q.rs2_data;
    assign bus.ex_imm      = ex_q.imm;
    assign bus.ex_rs1      = ex_q.rs1;
    assign bus.ex_rs2      = ex_q.rs2;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.ex_funct3   = ex_q.funct3;
    assign bus.ex_funct7b5 = ex_q.funct7b5;
    assign bus.ex_ctrl     = ex_q.ctrl;
    assign bus.bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and random stimulus for id_ex_stage against an instruction-slot reference model.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam logic [11:0] CT_ADD = 12'h044;
    localparam logic [11:0] CT_LW  = 12'h50C;
    localparam logic [11:0] CT_LUI = 12'h06C;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if bus();
    id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_cmp  = 0;
    int n_fail = 0;

    // What the EX slot should contain, tracked as an instruction record
    typedef struct {
        bit          valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
        logic [11:0] ctrl;
    } slot_t;

    slot_t m_ex;
    bit    m_pend  = 1'b0;
    int    m_cnt   = 0;
    bit    m_known = 1'b0;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_lu();
        if (!m_ex.valid || !m_ex.ctrl[10] || m_ex.rd == 5'd0 || !bus.id_valid) return 1'b0;
        return (bus.id_uses_rs1 && bus.id_rs1 == m_ex.rd) || (bus.id_uses_rs2 && bus.id_rs2 == m_ex.rd);
    endfunction

    task automatic check_outputs();
        chk("ex_valid", 160'(bus.ex_valid), 160'(m_ex.valid));
        chk("ex_ctrl", 160'(bus.ex_ctrl), 160'(m_ex.ctrl));
        chk("ex_pc", 160'(bus.ex_pc), 160'(m_ex.pc));
        chk("ex_rd", 160'(bus.ex_rd), 160'(m_ex.rd));
        chk("ex_data", 160'({bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm}),
            160'({m_ex.rs1d, m_ex.rs2d, m_ex.imm}));
        chk("ex_fields", 160'({bus.ex_rs1, bus.ex_rs2, bus.ex_funct3, bus.ex_funct7b5}),
            160'({m_ex.rs1, m_ex.rs2, m_ex.f3, m_ex.f7}));
        chk("bubble_cnt", 160'(bus.bubble_cnt), 160'(m_cnt));
    endtask

    // Let inputs settle and check the combinational stall
    task automatic settle();
        #1;
        if (m_known)
            chk("id_stall", 160'(bus.id_stall),
                160'(bus.ex_hold | (m_lu() & ~bus.ex_flush & ~m_pend)));
    endtask

    // Advance one clock, update the model from the pre-edge inputs, then check EX
    task automatic tick();
        bit lu;
        lu = m_known && m_lu();
        @(posedge clk);
        if (!rst) begin
            m_ex    = '{default: 0};
            m_pend  = 1'b0;
            m_cnt   = 0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (bus.ex_hold) begin
                m_pend = m_pend | bus.ex_flush;
            end else if (bus.ex_flush || m_pend || lu) begin
                m_ex   = '{default: 0};
                m_pend = 1'b0;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_ex.valid = bus.id_valid;
                m_ex.pc    = bus.id_pc;
                m_ex.rs1d  = bus.id_rs1_data;
                m_ex.rs2d  = bus.id_rs2_data;
                m_ex.imm   = bus.id_imm;
                m_ex.rs1   = bus.id_rs1;
                m_ex.rs2   = bus.id_rs2;
                m_ex.rd    = bus.id_rd;
                m_ex.f3    = bus.id_funct3;
                m_ex.f7    = bus.id_funct7b5;
                m_ex.ctrl  = bus.id_valid ? bus.id_ctrl : 12'h000;
            end
        end
        #1;
        if (m_known) check_outputs();
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic set_id(input bit v, input logic [31:0] pc, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input bit u1, input bit u2, input logic [11:0] ctrl);
        bus.id_valid    = v;
        bus.id_pc       = pc;
        bus.id_rd       = rd;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_uses_rs1 = u1;
        bus.id_uses_rs2 = u2;
        bus.id_ctrl     = ctrl;
        bus.id_rs1_data = $urandom;
        bus.id_rs2_data = $urandom;
        bus.id_imm      = $urandom;
        bus.id_funct3   = 3'($urandom_range(0, 7));
        bus.id_funct7b5 = 1'($urandom_range(0, 1));
    endtask

    initial begin
        bus.ex_flush = 1'b0;
        bus.ex_hold  = 1'b0;
        set_id(1'b1, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 12'h000);

        // T1: reset with random inputs
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_id(1'b1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 12'($urandom));
            bus.ex_hold  = 1'($urandom_range(0, 1));
            bus.ex_flush = 1'($urandom_range(0, 1));
            cycle();
        end
        chk("t1_valid", 160'(bus.ex_valid), 160'(0));
        chk("t1_cnt", 160'(bus.bubble_cnt), 160'(0));
        settle();
        chk("t1_stall", 160'(bus.id_stall), 160'(bus.ex_hold));
        rst = 1'b1;
        bus.ex_hold  = 1'b0;
        bus.ex_flush = 1'b0;

        // T2: add x3,x1,x2 at 0x100
        set_id(1'b1, 32'h100, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, CT_ADD);
        cycle();
        chk("t2_pc", 160'(bus.ex_pc), 160'(32'h100));
        chk("t2_rd", 160'(bus.ex_rd), 160'(3));
        chk("t2_ctrl", 160'(bus.ex_ctrl), 160'(CT_ADD));
        chk("t2_valid", 160'(bus.ex_valid), 160'(1));

        // T3: lw x5 then add x6,x5,x7
        set_id(1'b1, 32'h104, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, CT_LW);
        cycle();
        set_id(1'b1, 32'h108, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, CT_ADD);
        settle();
        chk("t3_stall", 160'(bus.id_stall), 160'(1));
        tick();
        chk("t3_bubble", 160'(bus.ex_ctrl), 160'(0));
        chk("t3_cnt", 160'(bus.bubble_cnt), 160'(1));
        settle();
        chk("t3_nostall", 160'(bus.id_stall), 160'(0));
        tick();
        chk("t3_add_pc", 160'(bus.ex_pc), 160'(32'h108));

        // T4: lw x0 / add x1,x0,x0 and lw x5 / lui x5
        set_id(1'b1, 32'h10c, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0, CT_LW);
        cycle();
        set_id(1'b1, 32'h110, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, CT_ADD);
        settle();
        chk("t4_x0", 160'(bus.id_stall), 160'(0));
        tick();
        set_id(1'b1, 32'h114, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, CT_LW);
        cycle();
        set_id(1'b1, 32'h118, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, CT_LUI);
        settle();
        chk("t4_lui", 160'(bus.id_stall), 160'(0));
        tick();

        // Store-data dependency: sw uses rs2
        set_id(1'b1, 32'h11c, 5'd9, 5'd1, 5'd0, 1'b1, 1'b0, CT_LW);
        cycle();
        set_id(1'b1, 32'h120, 5'd0, 5'd2, 5'd9, 1'b1, 1'b1, 12'h030);
        settle();
        chk("t4_store", 160'(bus.id_stall), 160'(1));
        tick();

        // T5: flush coinciding with load-use
        set_id(1'b1, 32'h124, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, CT_LW);
        cycle();
        set_id(1'b1, 32'h128, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, CT_ADD);
        bus.ex_flush = 1'b1;
        settle();
        chk("t5_stall", 160'(bus.id_stall), 160'(0));
        tick();
        bus.ex_flush = 1'b0;
        chk("t5_bubble", 160'(bus.ex_valid), 160'(0));
        chk("t5_cnt", 160'(bus.bubble_cnt), 160'(3));

        // T6: flush during 3-cycle hold
        set_id(1'b1, 32'h200, 5'd4, 5'd1, 5'd2, 1'b1, 1'b1, CT_ADD);
        cycle();
        set_id(1'b1, 32'h204, 5'd8, 5'd1, 5'd2, 1'b1, 1'b1, CT_ADD);
        bus.ex_hold  = 1'b1;
        bus.ex_flush = 1'b1;
        cycle();
        bus.ex_flush = 1'b0;
        cycle();
        cycle();
        chk("t6_frozen", 160'(bus.ex_pc), 160'(32'h200));
        bus.ex_hold = 1'b0;
        cycle();
        chk("t6_bubble", 160'(bus.ex_valid), 160'(0));
        chk("t6_cnt", 160'(bus.bubble_cnt), 160'(4));
        cycle();
        chk("t6_resume", 160'(bus.ex_pc), 160'(32'h204));

        // Reset mid-hold clears a pending flush
        bus.ex_hold  = 1'b1;
        bus.ex_flush = 1'b1;
        cycle();
        bus.ex_flush = 1'b0;
        rst = 1'b0;
        cycle();
        chk("t6_rst_cnt", 160'(bus.bubble_cnt), 160'(0));
        rst = 1'b1;
        bus.ex_hold = 1'b0;
        set_id(1'b1, 32'h300, 5'd2, 5'd1, 5'd1, 1'b1, 1'b1, CT_ADD);
        cycle();
        chk("t6_rst_valid", 160'(bus.ex_valid), 160'(1));
        chk("t6_rst_pc", 160'(bus.ex_pc), 160'(32'h300));

        // Random traffic with small register numbers to provoke hazards
        for (int i = 0; i < 2000; i++) begin
            logic [11:0] c;
            c = 12'($urandom);
            c[10] = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 99) != 0);
            set_id(($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c);
            bus.ex_flush = ($urandom_range(0, 9) == 0);
            bus.ex_hold  = ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
